// File: rtl/axi4_mem_pkg.sv
// Shared types and constants for the AXI4 INCR-only slave memory.
// Used by axi4_mem_slave and axi_lfsr16 (stall generator under AXI_MEM_RAND_STALL_EN).
package axi4_mem_pkg;

    localparam int          AXI_LEN_W = 8;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), reseeded on rst.
// Only instantiated when AXI_MEM_RAND_STALL_EN is defined.
module axi_lfsr16
    import axi4_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 INCR-only slave memory with independent read/write FSMs and byte strobes.
// Define AXI_MEM_RAND_STALL_EN to add LFSR-driven ready/rvalid stalls.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | accepting write beats until the latched length is reached
// W_RESP | bvalid high until bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | presenting beats from memory until the final beat is taken
module axi4_mem_slave
    import axi4_mem_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH          = 4096
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,

    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,

    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,

    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,

    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast,

    output logic                            wlast_err
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int IDX_HI = IDX_W + OFF_W - 1;

    localparam logic [IDX_W-1:0]     IDX_ONE = 1;
    localparam logic [AXI_LEN_W-1:0] LEN_ONE = 1;

    logic [C_M_AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Sub-word and above-depth address bits are deliberately ignored (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[C_M_AXI_ADDR_WIDTH-1:IDX_HI+1], s_axi_awaddr[OFF_W-1:0],
                                s_axi_araddr[C_M_AXI_ADDR_WIDTH-1:IDX_HI+1], s_axi_araddr[OFF_W-1:0]};

    logic stall;

`ifdef AXI_MEM_RAND_STALL_EN
    logic [15:0] lfsr;
    logic [14:0] unused_lfsr_bits;

    axi_lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr)
    );

    assign stall            = lfsr[0];
    assign unused_lfsr_bits = lfsr[15:1];
`else
    assign stall = 1'b0;
`endif

    wr_state_e                wr_state_q, wr_state_d;
    logic [IDX_W-1:0]         widx_q, widx_d;
    logic [AXI_LEN_W-1:0]     wlen_q, wlen_d;
    logic [AXI_LEN_W-1:0]     wcnt_q, wcnt_d;
    logic                     wlast_err_q, wlast_err_d;
    logic                     aw_hs, w_hs, w_last_beat;

    assign s_axi_awready = (wr_state_q == W_IDLE) & ~rst & ~stall;
    assign s_axi_wready  = (wr_state_q == W_DATA) & ~rst & ~stall;
    assign s_axi_bvalid  = (wr_state_q == W_RESP) & ~rst;
    assign wlast_err     = wlast_err_q & ~rst;

    assign aw_hs       = s_axi_awvalid & s_axi_awready;
    assign w_hs        = s_axi_wvalid & s_axi_wready;
    assign w_last_beat = (wcnt_q == wlen_q);

    always_comb begin
        wr_state_d  = wr_state_q;
        widx_d      = widx_q;
        wlen_d      = wlen_q;
        wcnt_d      = wcnt_q;
        wlast_err_d = wlast_err_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    widx_d     = s_axi_awaddr[IDX_HI:OFF_W];
                    wlen_d     = s_axi_awlen;
                    wcnt_d     = '0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    widx_d = widx_q + IDX_ONE;
                    wcnt_d = wcnt_q + LEN_ONE;
                    // wlast is only audited; the latched length decides the burst end.
                    if (s_axi_wlast != w_last_beat) begin
                        wlast_err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q  <= W_IDLE;
            widx_q      <= '0;
            wlen_q      <= '0;
            wcnt_q      <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            widx_q      <= widx_d;
            wlen_q      <= wlen_d;
            wcnt_q      <= wcnt_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    // Contents survive rst; w_hs is already gated off while rst is high.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[widx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    rd_state_e                rd_state_q, rd_state_d;
    logic [IDX_W-1:0]         ridx_q, ridx_d;
    logic [AXI_LEN_W-1:0]     rlen_q, rlen_d;
    logic [AXI_LEN_W-1:0]     rcnt_q, rcnt_d;
    logic                     rd_active, ar_hs, r_hs, r_last_beat;

    assign rd_active     = (rd_state_q == R_DATA) & ~rst;
    assign s_axi_arready = (rd_state_q == R_IDLE) & ~rst & ~stall;

`ifdef AXI_MEM_RAND_STALL_EN
    // Once raised, rvalid is held until taken so a stall never retracts a beat.
    logic rv_hold_q, rv_hold_d;

    assign s_axi_rvalid = rd_active & (rv_hold_q | ~stall);

    always_comb begin
        rv_hold_d = s_axi_rvalid & ~s_axi_rready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rv_hold_q <= 1'b0;
        end else begin
            rv_hold_q <= rv_hold_d;
        end
    end
`else
    assign s_axi_rvalid = rd_active;
`endif

    assign r_last_beat = (rcnt_q == rlen_q);
    assign s_axi_rdata = s_axi_rvalid ? mem_q[ridx_q] : '0;
    assign s_axi_rlast = s_axi_rvalid & r_last_beat;

    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign r_hs  = s_axi_rvalid & s_axi_rready;

    always_comb begin
        rd_state_d = rd_state_q;
        ridx_d     = ridx_q;
        rlen_d     = rlen_q;
        rcnt_d     = rcnt_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    ridx_d     = s_axi_araddr[IDX_HI:OFF_W];
                    rlen_d     = s_axi_arlen;
                    rcnt_d     = '0;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    ridx_d = ridx_q + IDX_ONE;
                    rcnt_d = rcnt_q + LEN_ONE;
                    if (r_last_beat) begin
                        rd_state_d = R_IDLE;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            ridx_q     <= '0;
            rlen_q     <= '0;
            rcnt_q     <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            ridx_q     <= ridx_d;
            rlen_q     <= rlen_d;
            rcnt_q     <= rcnt_d;
        end
    end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Self-checking bench for axi4_mem_slave against a word-array reference model.
// Latency checks are exact unless AXI_MEM_RAND_STALL_EN is defined.
module tb_axi4_mem_slave;

    localparam int DEPTH = 4096;
    localparam int TMO   = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_bvalid, s_axi_bready;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic        s_axi_rlast;
    logic        wlast_err;

    axi4_mem_slave #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .MEM_DEPTH          (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rlast   (s_axi_rlast),
        .wlast_err     (wlast_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] wq [$];
    logic [3:0]  sq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    // rvalid, once up without rready, must still be up a cycle later (unless in reset).
    logic prev_rv = 1'b0, prev_rr = 1'b0, prev_rst = 1'b1;
    always @(negedge clk) begin
        #3;
        if (!rst && !prev_rst && prev_rv && !prev_rr) begin
            tests++;
            assert (s_axi_rvalid === 1'b1) else begin
                fails++;
                $error("FAIL rvalid_drop: observed %b expected 1", s_axi_rvalid);
            end
        end
        prev_rv  = s_axi_rvalid;
        prev_rr  = s_axi_rready;
        prev_rst = rst;
    end

    // Drives one burst from wq/sq; bad_beat >= 0 puts wlast on that beat only.
    task automatic write_burst(input logic [31:0] addr, input int len, input int bad_beat);
        int n;
        int idx;
        idx = word_of(addr);
        @(negedge clk);
        s_axi_awaddr  = addr;
        s_axi_awlen   = 8'(len);
        s_axi_awvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axi_awready && n < TMO) begin @(negedge clk); #1; n++; end
        check("aw_handshake", 32'(n < TMO), 32'd1);
`ifndef AXI_MEM_RAND_STALL_EN
        check("aw_latency", n, 0);
`endif
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            @(negedge clk);
            s_axi_wdata  = wq[b];
            s_axi_wstrb  = sq[b];
            s_axi_wlast  = (bad_beat >= 0) ? (b == bad_beat) : (b == len);
            s_axi_wvalid = 1'b1;
            #1;
            n = 0;
            while (!s_axi_wready && n < TMO) begin @(negedge clk); #1; n++; end
            if (n >= TMO) begin
                check("w_handshake", 32'(n), 32'(TMO - 1));
                s_axi_wvalid = 1'b0;
                return;
            end
`ifndef AXI_MEM_RAND_STALL_EN
            if (b == 0) check("w_latency", n, 0);
`endif
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++)
                if (sq[b][k]) model[idx][8*k +: 8] = wq[b][8*k +: 8];
            idx = (idx + 1) % DEPTH;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        @(negedge clk);
        s_axi_bready = 1'b1;
        #1;
        n = 0;
        while (!s_axi_bvalid && n < TMO) begin @(negedge clk); #1; n++; end
        check("b_latency", n, 0);
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        check("b_single", 32'(s_axi_bvalid), 32'd0);
    endtask

    // Reads a burst and compares each beat to the model; stop_after >= 0 abandons it mid-burst.
    task automatic read_burst(input logic [31:0] addr, input int len, input int hold_beat,
                              input int hold, input bit rand_bp, input int stop_after);
        int n;
        int idx;
        int h;
        bit first;
        idx = word_of(addr);
        @(negedge clk);
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axi_arready && n < TMO) begin @(negedge clk); #1; n++; end
        check("ar_handshake", 32'(n < TMO), 32'd1);
`ifndef AXI_MEM_RAND_STALL_EN
        check("ar_latency", n, 0);
`endif
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        first = 1'b1;
        for (int b = 0; b <= len; b++) begin
            if (b == stop_after) return;
            h = (b == hold_beat) ? hold : (rand_bp ? int'($urandom_range(0, 2)) : 0);
            for (int c = 0; c < h; c++) begin
                @(negedge clk);
                s_axi_rready = 1'b0;
                #1;
`ifndef AXI_MEM_RAND_STALL_EN
                check("r_valid_held", 32'(s_axi_rvalid), 32'd1);
`endif
                if (s_axi_rvalid) begin
                    first = 1'b0;
                    check("r_hold_data", s_axi_rdata, model[idx]);
                    check("r_hold_last", 32'(s_axi_rlast), 32'(b == len));
                end
            end
            @(negedge clk);
            s_axi_rready = 1'b1;
            #1;
            n = 0;
            while (!s_axi_rvalid && n < TMO) begin @(negedge clk); #1; n++; end
            if (n >= TMO) begin
                check("r_handshake", 32'(n), 32'(TMO - 1));
                s_axi_rready = 1'b0;
                return;
            end
`ifndef AXI_MEM_RAND_STALL_EN
            if (first) check("r_latency", n, 0);
`endif
            first = 1'b0;
            check("r_data", s_axi_rdata, model[idx]);
            check("r_last", 32'(s_axi_rlast), 32'(b == len));
            @(posedge clk); #1;
            s_axi_rready = 1'b0;
            idx = (idx + 1) % DEPTH;
        end
        check("r_valid_after_last", 32'(s_axi_rvalid), 32'd0);
`ifndef AXI_MEM_RAND_STALL_EN
        check("ar_ready_after_last", 32'(s_axi_arready), 32'd1);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, 32'(s_axi_awready), 32'd0);
        check({tag, "_wready"},  32'(s_axi_wready),  32'd0);
        check({tag, "_bvalid"},  32'(s_axi_bvalid),  32'd0);
        check({tag, "_arready"}, 32'(s_axi_arready), 32'd0);
        check({tag, "_rvalid"},  32'(s_axi_rvalid),  32'd0);
        check({tag, "_rdata"},   s_axi_rdata,        32'd0);
        check({tag, "_rlast"},   32'(s_axi_rlast),   32'd0);
        check({tag, "_wlast_err"}, 32'(wlast_err),   32'd0);
    endtask

    task automatic fill(input int len, input bit full_strb);
        wq.delete();
        sq.delete();
        for (int i = 0; i <= len; i++) begin
            wq.push_back($urandom);
            sq.push_back(full_strb ? 4'hF : 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        logic [31:0] a;
        int len;

        rst = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0;
        s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0;
        s_axi_rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("in_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
`ifndef AXI_MEM_RAND_STALL_EN
        check("post_reset_awready", 32'(s_axi_awready), 32'd1);
        check("post_reset_arready", 32'(s_axi_arready), 32'd1);
`endif

        // Single write then read.
        wq = '{32'hDEADBEEF};
        sq = '{4'hF};
        write_burst(32'h10, 0, -1);
        read_burst(32'h10, 0, -1, 0, 1'b0, -1);

        // 256-beat burst with data = beat index.
        wq.delete(); sq.delete();
        for (int i = 0; i < 256; i++) begin wq.push_back(32'(i)); sq.push_back(4'hF); end
        write_burst(32'h0, 255, -1);
        check("burst_wlast_err", 32'(wlast_err), 32'd0);
        read_burst(32'h0, 255, -1, 0, 1'b0, -1);

        // Byte strobes.
        wq = '{32'h11223344};
        sq = '{4'hF};
        write_burst(32'h400, 0, -1);
        wq = '{32'hAABBCCDD};
        sq = '{4'b0101};
        write_burst(32'h400, 0, -1);
        read_burst(32'h400, 0, -1, 0, 1'b0, -1);

        // Wrap past the top word, with read backpressure on the first beat.
        fill(1, 1'b1);
        write_burst(32'((DEPTH - 1) * 4), 1, -1);
        read_burst(32'((DEPTH - 1) * 4), 1, 0, 5, 1'b0, -1);
        read_burst(32'h0, 0, -1, 0, 1'b0, -1);

        // wlast on the wrong beat: error flag set, all four beats still consumed.
        fill(3, 1'b1);
        write_burst(32'h800, 3, 1);
        check("wlast_err_set", 32'(wlast_err), 32'd1);
        read_burst(32'h800, 3, -1, 0, 1'b0, -1);

        // Reset in the middle of a read burst.
        read_burst(32'h0, 255, -1, 0, 1'b0, 3);
        @(negedge clk);
        rst = 1'b1;
        s_axi_rready = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
`ifndef AXI_MEM_RAND_STALL_EN
        check("reset_arready", 32'(s_axi_arready), 32'd1);
`endif
        check("reset_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("reset_wlast_err", 32'(wlast_err), 32'd0);
        read_burst(32'h800, 3, -1, 0, 1'b0, -1);

        // 64-beat random data with random backpressure.
        fill(63, 1'b1);
        write_burst(32'h2000, 63, -1);
        read_burst(32'h2000, 63, -1, 0, 1'b1, -1);

        // Random bursts: full-strobe preload, random-strobe overwrite, readback.
        for (int t = 0; t < 12; t++) begin
            a   = $urandom;
            len = int'($urandom_range(0, 31));
            fill(len, 1'b1);
            write_burst(a, len, -1);
            fill(len, 1'b0);
            write_burst(a, len, -1);
            read_burst(a, len, int'($urandom_range(0, len)), 3, 1'b1, -1);
        end
        check("final_wlast_err", 32'(wlast_err), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
